// File: rtl/data_memory_v3_if.sv
// Request/response bus between the MEM stage and data_memory_v3.
// The core side uses the master modport, the memory uses the slave modport.
interface data_memory_v3_if #(
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic              o_ready;
    logic              i_we;
    logic [2:0]        i_funct3;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wd;
    logic [31:0]       o_rd;
    logic              o_valid;
    logic              o_fault;

    modport master (
        output i_req, i_we, i_funct3, i_addr, i_wd,
        input  o_ready, o_rd, o_valid, o_fault
    );

    modport slave (
        input  i_req, i_we, i_funct3, i_addr, i_wd,
        output o_ready, o_rd, o_valid, o_fault
    );
endinterface

// File: rtl/data_memory_v3.sv
// RV32 data memory with built-in load/store unit.
// Word-organised RAM, byte-lane stores, sign/zero-extending loads, and a
// req/ready/valid handshake with RD_LAT cycles from accept to o_valid.
// Optional build macro DM_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses fault; when undefined, low address bits are forced to alignment.
//
// state | meaning
// IDLE  | o_ready=1, waiting for a request
// WAIT  | latency counter running (only when RD_LAT>1)
// RESP  | o_valid=1 for one cycle, then back to IDLE

`ifndef DM_DEPTH
`define DM_DEPTH 1024
`endif
`ifndef DM_FILE
`define DM_FILE ""
`endif

module data_memory_v3 #(
    parameter int    DEPTH     = `DM_DEPTH,
    parameter string INIT_FILE = `DM_FILE,
    parameter int    RD_LAT    = 1,
    parameter int    ADDR_W    = 32
) (
    input logic             i_clk,
    input logic             i_rst,
    data_memory_v3_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] pend_rd;
    logic        pend_fault;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] widx;
    logic [1:0]    size;
    logic [1:0]    lane;
    logic          oob;
    logic          f3_bad;
    logic          fault;
    logic          accept;
    logic [31:0]   rd_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ld_val;
    logic [31:0]   resp_val;
    logic [3:0]    be;
    logic [31:0]   wdata;

    // Decode the request: legality, lane selection, load extraction, store lanes
    always_comb begin
        widx     = bus.i_addr[AW+1:2];
        size     = bus.i_funct3[1:0];
        oob      = {2'b00, bus.i_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH);
        if (bus.i_we)
            f3_bad = bus.i_funct3 > 3'd2;
        else
            f3_bad = (bus.i_funct3 == 3'b011) || (bus.i_funct3[2:1] == 2'b11);
`ifdef DM_MISALIGN_TRAP_EN
        lane  = bus.i_addr[1:0];
        fault = oob || f3_bad ||
                ((size == 2'b01) && bus.i_addr[0]) ||
                ((size == 2'b10) && (bus.i_addr[1:0] != 2'b00));
`else
        // Misaligned addresses are silently rounded down to the access size
        case (size)
            2'b01:   lane = {bus.i_addr[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = bus.i_addr[1:0];
        endcase
        fault = oob || f3_bad;
`endif
        accept   = bus.i_req && bus.o_ready && !i_rst;

        rd_word  = mem[widx];
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.i_funct3)
            3'b000:  ld_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  ld_val = rd_word;
            3'b100:  ld_val = {24'h0, byte_sel};
            3'b101:  ld_val = {16'h0, half_sel};
            default: ld_val = 32'h0;
        endcase
        // Stores and rejected accesses always answer with zero
        resp_val = (fault || bus.i_we) ? 32'h0 : ld_val;

        case (size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.i_wd[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.i_wd[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = bus.i_wd;
            end
        endcase
    end

    // Store commit at the accept edge, per byte lane
    always_ff @(posedge i_clk) begin
        if (accept && bus.i_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Handshake FSM with registered outputs and latency down-counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            pend_rd     <= 32'h0;
            pend_fault  <= 1'b0;
            bus.o_rd    <= 32'h0;
            bus.o_valid <= 1'b0;
            bus.o_fault <= 1'b0;
            bus.o_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.o_ready <= 1'b0;
                        if (RD_LAT > 1) begin
                            state      <= WAIT;
                            cnt        <= 2'(RD_LAT - 2);
                            pend_rd    <= resp_val;
                            pend_fault <= fault;
                        end else begin
                            state       <= RESP;
                            bus.o_rd    <= resp_val;
                            bus.o_fault <= fault;
                            bus.o_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state       <= RESP;
                        bus.o_rd    <= pend_rd;
                        bus.o_fault <= pend_fault;
                        bus.o_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    bus.o_valid <= 1'b0;
                    bus.o_fault <= 1'b0;
                    bus.o_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    bus.o_valid <= 1'b0;
                    bus.o_fault <= 1'b0;
                    bus.o_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_v3.sv
// Directed testbench for data_memory_v3: table of load/store vectors on an
// RD_LAT=3 instance, plus hand sequences for hold-off, reset and an RD_LAT=1 instance.
module tb_data_memory_v3;
    localparam int LAT   = 3;
    localparam int DEPTH = 16;
`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    data_memory_v3_if #(.ADDR_W(32)) bus3 ();
    data_memory_v3_if #(.ADDR_W(32)) bus1 ();

    data_memory_v3 #(.DEPTH(DEPTH), .INIT_FILE(""), .RD_LAT(LAT), .ADDR_W(32)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus3.slave)
    );

    data_memory_v3 #(.DEPTH(DEPTH), .INIT_FILE(""), .RD_LAT(1), .ADDR_W(32)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_fault;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_fault, input string name);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_fault = exp_fault; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one access on the RD_LAT=3 instance and check latency and response
    task automatic do_access(input vec_t v);
        int  k;
        bit  got;
        k = 0;
        while (!bus3.o_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({v.name, " ready"}, 32'(bus3.o_ready), 32'd1);
        bus3.i_req    = 1'b1;
        bus3.i_we     = v.we;
        bus3.i_funct3 = v.f3;
        bus3.i_addr   = v.addr;
        bus3.i_wd     = v.wd;
        @(posedge clk);
        #1 bus3.i_req = 1'b0;
        k   = 0;
        got = 1'b0;
        while (k < LAT + 5 && !got) begin
            @(negedge clk);
            k++;
            if (bus3.o_valid) got = 1'b1;
        end
        chk({v.name, " latency"}, 32'(k), 32'(LAT));
        chk({v.name, " rd"}, bus3.o_rd, v.exp_rd);
        chk({v.name, " fault"}, 32'(bus3.o_fault), 32'(v.exp_fault));
        @(negedge clk);
        chk({v.name, " valid drop"}, 32'(bus3.o_valid), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus3.i_req = 1'b0; bus3.i_we = 1'b0; bus3.i_funct3 = 3'd0; bus3.i_addr = 32'h0; bus3.i_wd = 32'h0;
        bus1.i_req = 1'b0; bus1.i_we = 1'b0; bus1.i_funct3 = 3'd0; bus1.i_addr = 32'h0; bus1.i_wd = 32'h0;

        add(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw 10");
        add(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw 10");
        add(1, 3'b000, 32'h12, 32'h000000AA, 32'h0, 0, "sb 12");
        add(0, 3'b010, 32'h10, 32'h0, 32'hDEAABEEF, 0, "lw 10 after sb");
        add(0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFAA, 0, "lb 12");
        add(0, 3'b100, 32'h12, 32'h0, 32'h000000AA, 0, "lbu 12");
        add(1, 3'b010, 32'h14, 32'h0, 32'h0, 0, "sw 14 clear");
        add(1, 3'b001, 32'h14, 32'hABCD8001, 32'h0, 0, "sh 14");
        add(0, 3'b001, 32'h16, 32'h0, 32'h00000000, 0, "lh 16");
        add(0, 3'b001, 32'h14, 32'h0, 32'hFFFF8001, 0, "lh 14");
        add(0, 3'b101, 32'h14, 32'h0, 32'h00008001, 0, "lhu 14");
        add(0, 3'b010, 32'h11, 32'h0, TRAP ? 32'h0 : 32'hDEAABEEF, TRAP, "lw 11");
        add(1, 3'b010, 32'h00, 32'h11111111, 32'h0, 0, "sw 00");
        add(0, 3'b010, 32'h40, 32'h0, 32'h0, 1, "lw oob");
        add(1, 3'b010, 32'h40, 32'h22222222, 32'h0, 1, "sw oob");
        add(0, 3'b010, 32'h00, 32'h0, 32'h11111111, 0, "lw 00 after oob");
        add(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "load f3 011");
        add(0, 3'b110, 32'h10, 32'h0, 32'h0, 1, "load f3 110");
        add(0, 3'b111, 32'h10, 32'h0, 32'h0, 1, "load f3 111");
        add(1, 3'b100, 32'h10, 32'h0, 32'h0, 1, "store f3 100");
        add(1, 3'b011, 32'h10, 32'h0, 32'h0, 1, "store f3 011");
        add(0, 3'b010, 32'h10, 32'h0, 32'hDEAABEEF, 0, "lw 10 after bad st");
        add(1, 3'b000, 32'h13, 32'hFFFFFF55, 32'h0, 0, "sb 13");
        add(0, 3'b000, 32'h13, 32'h0, 32'h00000055, 0, "lb 13");
        add(0, 3'b101, 32'h12, 32'h0, 32'h000055AA, 0, "lhu 12");
        add(0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 0, "lh 10");
        add(1, 3'b001, 32'h17, 32'h00001234, 32'h0, TRAP, "sh 17");
        add(0, 3'b010, 32'h14, 32'h0, TRAP ? 32'h00008001 : 32'h12348001, 0, "lw 14");
        add(0, 3'b001, 32'h13, 32'h0, TRAP ? 32'h0 : 32'h000055AA, TRAP, "lh 13");
        add(0, 3'b010, 32'h12, 32'h0, TRAP ? 32'h0 : 32'h55AABEEF, TRAP, "lw 12");
        add(1, 3'b010, 32'h02, 32'h77777777, 32'h0, TRAP, "sw 02");
        add(0, 3'b010, 32'h00, 32'h0, TRAP ? 32'h11111111 : 32'h77777777, 0, "lw 00");
        add(1, 3'b010, 32'h3C, 32'hAABBCCDD, 32'h0, 0, "sw last");
        add(0, 3'b100, 32'h3F, 32'h0, 32'h000000AA, 0, "lbu last+3");

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset ready", 32'(bus3.o_ready), 32'd1);
        chk("reset valid", 32'(bus3.o_valid), 32'd0);
        chk("reset rd", bus3.o_rd, 32'h0);
        chk("reset fault", 32'(bus3.o_fault), 32'd0);

        for (int i = 0; i < vecs.size(); i++) do_access(vecs[i]);

        // Held request is ignored until o_ready returns, then accepted at once
        bus3.i_req = 1'b1; bus3.i_we = 1'b0; bus3.i_funct3 = 3'b010; bus3.i_addr = 32'h10;
        @(posedge clk);
        #1 bus3.i_addr = 32'h3C;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) bus3.i_req = 1'b0;
            chk($sformatf("hold ready k%0d", k), 32'(bus3.o_ready), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("hold valid k%0d", k), 32'(bus3.o_valid), (k == 3 || k == 7) ? 32'd1 : 32'd0);
            if (k == 3) chk("hold rd first", bus3.o_rd, 32'h55AABEEF);
            if (k == 7) chk("hold rd second", bus3.o_rd, 32'hAABBCCDD);
        end
        @(negedge clk);

        // Reset during WAIT drops the response
        bus3.i_req = 1'b1; bus3.i_we = 1'b0; bus3.i_funct3 = 3'b010; bus3.i_addr = 32'h10;
        @(posedge clk);
        #1 bus3.i_req = 1'b0;
        @(negedge clk);
        chk("rst wait ready", 32'(bus3.o_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst valid", 32'(bus3.o_valid), 32'd0);
        chk("rst rd", bus3.o_rd, 32'h0);
        chk("rst fault", 32'(bus3.o_fault), 32'd0);
        chk("rst ready", 32'(bus3.o_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst no valid %0d", k), 32'(bus3.o_valid), 32'd0);
        end

        // Reset and store on the same edge: nothing written
        rst = 1'b1;
        bus3.i_req = 1'b1; bus3.i_we = 1'b1; bus3.i_funct3 = 3'b010; bus3.i_addr = 32'h10; bus3.i_wd = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        bus3.i_req = 1'b0;
        do_access('{we: 1'b0, f3: 3'b010, addr: 32'h10, wd: 32'h0,
                    exp_rd: 32'h55AABEEF, exp_fault: 1'b0, name: "lw 10 after rst+sw"});

        // RD_LAT=1 instance: response in the cycle right after accept
        bus1.i_req = 1'b1; bus1.i_we = 1'b1; bus1.i_funct3 = 3'b010; bus1.i_addr = 32'h08; bus1.i_wd = 32'hCAFEF00D;
        @(posedge clk);
        #1 bus1.i_we = 1'b0;
        @(negedge clk);
        chk("lat1 sw valid", 32'(bus1.o_valid), 32'd1);
        chk("lat1 sw rd", bus1.o_rd, 32'h0);
        chk("lat1 sw fault", 32'(bus1.o_fault), 32'd0);
        chk("lat1 busy", 32'(bus1.o_ready), 32'd0);
        @(negedge clk);
        chk("lat1 idle valid", 32'(bus1.o_valid), 32'd0);
        chk("lat1 idle ready", 32'(bus1.o_ready), 32'd1);
        @(negedge clk);
        bus1.i_req = 1'b0;
        chk("lat1 lw valid", 32'(bus1.o_valid), 32'd1);
        chk("lat1 lw rd", bus1.o_rd, 32'hCAFEF00D);
        @(negedge clk);
        chk("lat1 rd hold", bus1.o_rd, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
